subtractor_serial_ctrl: RTL and testbench
=========================================

Name: subtractor_serial_ctrl

Overview:
- Bit-serial N-bit subtraction controller that time-shares one 1-bit full-subtractor cell (`subtractor`: `a_i`, `b_i`, `c_i` -> `diff_o`, `borrow_o`) across all operand bits.
- Processes bits LSB first, one bit per clock, and carries the borrow between bits in a register.
- Computes diff = a - b (unsigned, modulo 2^WIDTH) and reports the final borrow.
- Sits between a requesting PE control path and the subtractor datapath cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; accepted only when ready_o=1.
- a_i  in  WIDTH  minuend, sampled on the accept cycle.
- b_i  in  WIDTH  subtrahend, sampled on the accept cycle.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse; result valid.
- diff_o  out  WIDTH  result register.
- borrow_o  out  1  final borrow; 1 means a < b (unsigned).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is clk_i, reset is rst_i.
- Reset values: state=IDLE, ready_o=1, done_o=0, diff_o=0, borrow_o=0, internal shift registers, borrow register and counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1: latch a_i/b_i into shift registers a_sh/b_sh, set borrow_q to 0, set cnt to 0, go to RUN.
  - On start_i=0: stay in IDLE.
- RUN:
  - ready_o=0.
  - Cell inputs: a=a_sh[0], b=b_sh[0], c=borrow_q.
  - Each cycle: borrow_q <= cell borrow; diff bit shifted into res_sh at the MSB (res_sh shifts right); a_sh/b_sh shift right.
  - cnt increments each cycle.
  - When cnt==WIDTH-1: perform the last bit, go to DONE.
- DONE (one cycle):
  - done_o=1.
  - diff_o <= res_sh and borrow_o <= borrow_q, registered at entry so they are valid while done_o=1.
  - Next state is IDLE unconditionally.
- Latency: start accepted at edge 0 -> done_o high in cycle WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- diff_o/borrow_o hold their value until the next DONE or reset. They are not cleared on a new accept.
- start_i while ready_o=0 is ignored, with no side effects. start_i held high continuously is accepted again in the first IDLE cycle after DONE.
- Operand changes on a_i/b_i after the accept cycle have no effect.
- Reset mid-operation (RUN or DONE): next cycle is IDLE with all reset values. The partial result is discarded and done_o is not pulsed.
- Reset has priority over start_i in the same cycle.
- Arithmetic: modulo 2^WIDTH. Wrap examples: 0 - 1 gives all-ones with borrow 1; a==b gives 0 with borrow 0.

Optional Feature:
- Macro: SUBTRACTOR_SERIAL_BORROW_IN_EN.
- Defined:
  - Adds port borrow_i (in, 1), sampled on the accept cycle as the initial borrow_q.
  - Result = a - b - borrow_i.
  - Enables multi-word chained subtraction using the previous borrow_o.
- Undefined:
  - No borrow_i port.
  - Initial borrow_q is always 0.

Decomposition:
- Package subtractor_serial_pkg contains:
  - state enum (IDLE, RUN, DONE), 2-bit;
  - function for counter width = $clog2(WIDTH);
  - constant MAX_WIDTH=32.
- Sub-module: instantiate the existing 1-bit `subtractor` cell once.
- Counter, shift registers and FSM stay in this block. No further sub-modules.

Test Plan (WIDTH=8):
1. Reset: rst_i=1 for 2 cycles, then 0 -> ready_o=1, done_o=0, diff_o=0x00, borrow_o=0.
2. a=0x5A, b=0x23, start pulse -> done_o high exactly 9 cycles after accept, diff_o=0x37, borrow_o=0, ready_o returns to 1 the following cycle.
3. a=0x00, b=0x01 -> diff_o=0xFF, borrow_o=1. Then a=0xC4, b=0xC4 -> diff_o=0x00, borrow_o=0.
4. Start 0x10-0x01, then pulse start_i with a=0xFF, b=0x00 during RUN cycle 3 -> ignored; diff_o=0x0F, only one done_o pulse.
5. Start 0x80-0x01, assert rst_i in RUN cycle 4 -> IDLE next cycle, no done_o, diff_o=0x00. Then 0x09-0x04 -> diff_o=0x05.
6. start_i held high with a=0x03, b=0x05 -> consecutive done_o pulses spaced 10 cycles apart, each with diff_o=0xFE, borrow_o=1. With SUBTRACTOR_SERIAL_BORROW_IN_EN: a=0x10, b=0x0F, borrow_i=1 -> diff_o=0x00, borrow_o=0.

Source files
------------

// File: rtl/subtractor_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial subtraction controller.
package subtractor_serial_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit-index counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/subtractor.sv
// 1-bit full-subtractor cell: diff = a - b - c, with borrow out.
module subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic diff_o,
  output logic borrow_o
);

  assign diff_o   = a_i ^ b_i ^ c_i;
  assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & c_i);

endmodule

// File: rtl/subtractor_serial_ctrl.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through one shared cell.
// Define SUBTRACTOR_SERIAL_BORROW_IN_EN to add a borrow_i input for chained multi-word subtraction.
module subtractor_serial_ctrl
  import subtractor_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
  input  logic             borrow_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  // Only the upper WIDTH-1 result bits need storing; the final bit is spliced in on the last step.
  logic [WIDTH-2:0] res_sh_q;
  logic             borrow_q;
  logic [CntW-1:0]  cnt_q;

  logic             cell_diff;
  logic             cell_borrow;
  logic             borrow_init;
  logic [WIDTH-1:0] res_next;

`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
  assign borrow_init = borrow_i;
`else
  assign borrow_init = 1'b0;
`endif

  assign res_next = {cell_diff, res_sh_q};

  subtractor u_cell (
    .a_i      (a_sh_q[0]),
    .b_i      (b_sh_q[0]),
    .c_i      (borrow_q),
    .diff_o   (cell_diff),
    .borrow_o (cell_borrow)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      diff_o   <= '0;
      borrow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_sh_q   <= a_i;
            b_sh_q   <= b_i;
            borrow_q <= borrow_init;
            cnt_q    <= '0;
            ready_o  <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_next[WIDTH-1:1];
          borrow_q <= cell_borrow;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            // Capture the completed result on the way into DONE so it is valid with done_o.
            diff_o   <= res_next;
            borrow_o <= cell_borrow;
            done_o   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          ready_o <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_o <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial_ctrl.sv
// Self-checking bench for subtractor_serial_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_subtractor_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
  logic         bin_in;
`endif

  int n_cmp = 0;
  int n_err = 0;

  subtractor_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
    .borrow_i (bin_in),
`endif
    .a_i      (a_in),
    .b_i      (b_in),
    .ready_o  (ready),
    .done_o   (done),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: {borrow, diff} of a - b - bin as plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    int d;
    d = int'(a) - int'(b) - int'(bin);
    return {d < 0, W'(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, " ready_wait"}, 32'(ready), 32'd1);
  endtask

  // One full operation from accept to done, with operands scrambled after accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input string tag);
    logic [W:0] exp;
    int         k;
    exp = model(a, b, bin);
    wait_ready(tag);
    a_in  = a;
    b_in  = b;
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
    bin_in = bin;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
    bin_in = 1'($urandom);
`endif
    chk({tag, " busy"}, 32'(ready), 32'd0);
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(W + 1));
    chk({tag, " diff"}, 32'(diff), 32'(exp[W-1:0]));
    chk({tag, " borrow"}, 32'(borrow), 32'(exp[W]));
    tick();
    chk({tag, " ready_after"}, 32'(ready), 32'd1);
    chk({tag, " done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int         dones;
    int         q[$];
    logic [W:0] e;
    logic       rb;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
    bin_in = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset borrow", 32'(borrow), 32'd0);

    run_op(8'h5A, 8'h23, 1'b0, "basic");
    run_op(8'h00, 8'h01, 1'b0, "wrap");
    run_op(8'hC4, 8'hC4, 1'b0, "equal");
    run_op(8'hFF, 8'h00, 1'b0, "max");
    run_op(8'h00, 8'hFF, 1'b0, "min");

    // Start pulse during RUN must be ignored.
    wait_ready("ignore");
    a_in  = 8'h10;
    b_in  = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a_in  = 8'hFF;
    b_in  = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 4; c <= 30; c++) begin
      if (done === 1'b1) begin
        dones++;
        chk("ignore done_cycle", 32'(c), 32'(W + 1));
        chk("ignore diff", 32'(diff), 32'h0F);
        chk("ignore borrow", 32'(borrow), 32'd0);
      end
      tick();
    end
    chk("ignore pulse_count", 32'(dones), 32'd1);

    // Reset mid-run discards the operation and clears the result.
    wait_ready("midrst");
    a_in  = 8'h80;
    b_in  = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst diff", 32'(diff), 32'd0);
    chk("midrst borrow", 32'(borrow), 32'd0);
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("midrst no_done", 32'(dones), 32'd0);
    run_op(8'h09, 8'h04, 1'b0, "after_rst");

    // Reset wins over a simultaneous start.
    a_in  = 8'h33;
    b_in  = 8'h11;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_prio ready", 32'(ready), 32'd1);
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("rst_prio no_done", 32'(dones), 32'd0);
    chk("rst_prio diff", 32'(diff), 32'd0);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    wait_ready("held");
    a_in  = 8'h03;
    b_in  = 8'h05;
    start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (done === 1'b1) begin
        q.push_back(c);
        chk("held diff", 32'(diff), 32'hFE);
        chk("held borrow", 32'(borrow), 32'd1);
      end
    end
    start = 1'b0;
    chk("held pulse_count", 32'(q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("held pulse_cycle", (q.size() > i) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(W + 1 + i * (W + 2)));
    end

`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
    run_op(8'h10, 8'h0F, 1'b1, "bin_chain");
    run_op(8'h00, 8'h00, 1'b1, "bin_wrap");
`endif

    for (int i = 0; i < 20; i++) begin
      e  = '0;
      rb = 1'b0;
`ifdef SUBTRACTOR_SERIAL_BORROW_IN_EN
      rb = 1'($urandom);
`endif
      e[W-1:0] = W'($urandom);
      run_op(e[W-1:0], W'($urandom), rb, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
